// File: rtl/arp_rx_if.sv
// GMII receive bus plus the parsed-ARP result bundle.
// The master drives the GMII bytes; the slave (arp_rx) returns the result.
interface arp_rx_if;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        arp_rx_done;
    logic        arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;

    modport master (
        output gmii_rx_dv, gmii_rxd,
        input  arp_rx_done, arp_rx_type, src_mac, src_ip
    );

    modport slave (
        input  gmii_rx_dv, gmii_rxd,
        output arp_rx_done, arp_rx_type, src_mac, src_ip
    );
endinterface

// File: rtl/arp_rx.sv
// GMII receive-side ARP parser: validates preamble, Ethernet header and ARP payload,
// then pulses arp_rx_done with the opcode type and the sender's MAC/IP.
module arp_rx #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
    input  logic     clk,
    input  logic     rst,
    arp_rx_if.slave  rx
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, ETH_HEAD, ARP_DATA, RX_END} state_t;

    localparam logic [7:0] MAC_B [6] = '{BOARD_MAC[47:40], BOARD_MAC[39:32], BOARD_MAC[31:24],
                                         BOARD_MAC[23:16], BOARD_MAC[15:8],  BOARD_MAC[7:0]};

    state_t      state;
    logic [4:0]  cnt;
    logic        uni_ok, bc_ok;
    logic        sh_op;
    logic [47:0] sh_mac;
    logic [31:0] sh_ip;
    logic [23:0] sh_tip;

    logic        uni_nxt, bc_nxt, eth_ok, arp_ok;
    logic [7:0]  rxd;

    assign rxd = rx.gmii_rxd;

    // Destination MAC must match the board unicast address or broadcast across all six bytes.
    always_comb begin
        uni_nxt = uni_ok;
        bc_nxt  = bc_ok;
        eth_ok  = 1'b1;
        if (cnt < 5'd6) begin
            uni_nxt = uni_ok && (rxd == MAC_B[cnt[2:0]]);
            bc_nxt  = bc_ok && (rxd == 8'hFF);
            eth_ok  = uni_nxt || bc_nxt;
        end else if (cnt == 5'd12) begin
            eth_ok = (rxd == 8'h08);
        end else if (cnt == 5'd13) begin
            eth_ok = (rxd == 8'h06);
        end
    end

    always_comb begin
        arp_ok = 1'b1;
        case (cnt)
            5'd0:    arp_ok = (rxd == 8'h00);
            5'd1:    arp_ok = (rxd == 8'h01);
            5'd2:    arp_ok = (rxd == 8'h08);
            5'd3:    arp_ok = (rxd == 8'h00);
            5'd4:    arp_ok = (rxd == 8'h06);
            5'd5:    arp_ok = (rxd == 8'h04);
            5'd6:    arp_ok = (rxd == 8'h00);
            5'd7:    arp_ok = (rxd == 8'h01) || (rxd == 8'h02);
            5'd27:   arp_ok = ({sh_tip, rxd} == BOARD_IP);
            default: arp_ok = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            uni_ok         <= 1'b0;
            bc_ok          <= 1'b0;
            sh_op          <= 1'b0;
            sh_mac         <= '0;
            sh_ip          <= '0;
            sh_tip         <= '0;
            rx.arp_rx_done <= 1'b0;
            rx.arp_rx_type <= 1'b0;
            rx.src_mac     <= '0;
            rx.src_ip      <= '0;
        end else begin
            // NOTE: non-blocking throughout; done defaults low each edge so it can only ever be a 1-cycle pulse.
            rx.arp_rx_done <= 1'b0;
            if (!rx.gmii_rx_dv) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rxd == 8'h55) begin
                            state <= PREAMBLE;
                            cnt   <= 5'd1;
                        end else begin
                            state <= RX_END;
                        end
                    end
                    PREAMBLE: begin
                        if (rxd == 8'h55 && cnt < 5'd7) begin
                            cnt <= cnt + 5'd1;
                        end else if (rxd == 8'hD5 && cnt == 5'd7) begin
                            state  <= ETH_HEAD;
                            cnt    <= '0;
                            uni_ok <= 1'b1;
                            bc_ok  <= 1'b1;
                        end else begin
                            state <= RX_END;
                        end
                    end
                    ETH_HEAD: begin
                        if (!eth_ok) begin
                            state <= RX_END;
                        end else begin
                            uni_ok <= uni_nxt;
                            bc_ok  <= bc_nxt;
                            if (cnt == 5'd13) begin
                                state <= ARP_DATA;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                    end
                    ARP_DATA: begin
                        if (!arp_ok) begin
                            state <= RX_END;
                        end else begin
                            // Sender fields go to shadow regs so a later reject never touches the outputs.
                            if (cnt == 5'd7)                     sh_op  <= rxd[1];
                            if (cnt >= 5'd8 && cnt <= 5'd13)     sh_mac <= {sh_mac[39:0], rxd};
                            if (cnt >= 5'd14 && cnt <= 5'd17)    sh_ip  <= {sh_ip[23:0], rxd};
                            if (cnt >= 5'd24 && cnt <= 5'd26)    sh_tip <= {sh_tip[15:0], rxd};
                            if (cnt == 5'd27) begin
                                state          <= RX_END;
                                rx.arp_rx_done <= 1'b1;
                                rx.arp_rx_type <= sh_op;
                                rx.src_mac     <= sh_mac;
                                rx.src_ip      <= sh_ip;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                    end
                    RX_END:  state <= RX_END;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
